// File: rtl/calc_pkg.sv
// Shared calculator datapath types and helpers.
// Holds the entry FSM state type, digit width and operand width helper.
package calc_pkg;

   typedef enum logic {
      ENTRY       = 1'b0,
      SHOW_RESULT = 1'b1
   } entry_state_t;

   localparam int DIGIT_W = 4;

   // Sign bit on top of DIGITS packed 4-bit digits.
   function automatic int op_width(input int digits);
      return digits * DIGIT_W + 1;
   endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Operand entry register: digit shift-in, backspace, sign toggle, clear.
// Ports: clk/nrst; clr_i, shift_i, bksp_i, tog_i (one active at a time),
// restart_i (treat entry as empty first), digit_i; entry_o, sign_o, full_o.
module digit_shift_reg
   import calc_pkg::*;
#(
   parameter int DIGITS = 2,
   localparam int W     = DIGITS * DIGIT_W,
   localparam int CW    = $clog2(DIGITS + 1)
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               clr_i,
   input  logic               shift_i,
   input  logic               bksp_i,
   input  logic               tog_i,
   input  logic               restart_i,
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [W-1:0]       entry_o,
   output logic               sign_o,
   output logic               full_o
);

   logic [W-1:0]  entry_q, entry_d;
   logic          sign_q, sign_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      entry_d = entry_q;
      sign_d  = sign_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         entry_d = '0;
         sign_d  = 1'b0;
         cnt_d   = '0;
      end else if (bksp_i) begin
         if (cnt_q != '0) begin
            entry_d = entry_q >> DIGIT_W;
            cnt_d   = cnt_q - 1'b1;
         end
      end else if (tog_i) begin
         if (restart_i) begin
            // Leaving the result view starts a fresh negative entry.
            entry_d = '0;
            cnt_d   = '0;
            sign_d  = 1'b1;
         end else begin
            sign_d = ~sign_q;
         end
      end else if (shift_i) begin
         if (restart_i) begin
            entry_d = W'(digit_i);
            cnt_d   = CW'(1);
            sign_d  = 1'b0;
         end else if (!full_o) begin
            // Shift truncates to W bits, so DIGITS==1 simply loads digit.
            entry_d = (entry_q << DIGIT_W) | W'(digit_i);
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         entry_q <= '0;
         sign_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         entry_q <= entry_d;
         sign_q  <= sign_d;
         cnt_q   <= cnt_d;
      end
   end

   assign entry_o = entry_q;
   assign sign_o  = sign_q;
   assign full_o  = (cnt_q == CW'(DIGITS));

endmodule

// File: rtl/operand_entry_buffer.sv
// Keypad operand buffer: assembles sign-magnitude operands, commits them
// into NUM_OPS slots, latches ALU results and drives the display value.
// Ports: clk/nrst; keypad strobes (digit, store_digit, backspace,
// toggle_sign, commit, clear); result/result_ready from the ALU;
// ops/ops_valid/all_ready slot bank; ssdec/disp_sign display;
// overflow pulse; showing_result state flag.
module operand_entry_buffer
   import calc_pkg::*;
#(
   parameter int DIGITS  = 2,
   parameter int NUM_OPS = 2,
   parameter int OP_W    = op_width(DIGITS)
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [DIGIT_W-1:0]      digit,
   input  logic                    store_digit,
   input  logic                    backspace,
   input  logic                    toggle_sign,
   input  logic                    commit,
   input  logic                    clear,
   input  logic [OP_W-1:0]         result,
   input  logic                    result_ready,
   output logic [NUM_OPS*OP_W-1:0] ops,
   output logic [NUM_OPS-1:0]      ops_valid,
   output logic                    all_ready,
   output logic [DIGITS*4-1:0]     ssdec,
   output logic                    disp_sign,
   output logic                    overflow,
   output logic                    showing_result
);

   localparam int W  = DIGITS * DIGIT_W;
   localparam int PW = $clog2(NUM_OPS + 1);

   entry_state_t              state_q, state_d;
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [NUM_OPS*OP_W-1:0]   ops_q, ops_d;
   logic [NUM_OPS-1:0]        vld_q, vld_d;
   logic [OP_W-1:0]           res_q, res_d;
   logic                      ovf_q, ovf_d;

   logic                      sr_clr, sr_shift, sr_bksp, sr_tog;
   logic [W-1:0]              entry;
   logic                      sign;
   logic                      full;
   logic                      can_commit;

   assign can_commit = (wr_ptr_q != PW'(NUM_OPS));

   digit_shift_reg #(
      .DIGITS(DIGITS)
   ) u_entry (
      .clk      (clk),
      .nrst     (nrst),
      .clr_i    (sr_clr),
      .shift_i  (sr_shift),
      .bksp_i   (sr_bksp),
      .tog_i    (sr_tog),
      .restart_i(state_q == SHOW_RESULT),
      .digit_i  (digit),
      .entry_o  (entry),
      .sign_o   (sign),
      .full_o   (full)
   );

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      ops_d    = ops_q;
      vld_d    = vld_q;
      res_d    = res_q;
      ovf_d    = 1'b0;
      sr_clr   = 1'b0;
      sr_shift = 1'b0;
      sr_bksp  = 1'b0;
      sr_tog   = 1'b0;
      priority case (1'b1)
         clear: begin
            sr_clr   = 1'b1;
            vld_d    = '0;
            wr_ptr_d = '0;
            state_d  = ENTRY;
         end
         result_ready: begin
            // The ALU consumed the operands, so the bank empties.
            res_d    = result;
            state_d  = SHOW_RESULT;
            vld_d    = '0;
            wr_ptr_d = '0;
            sr_clr   = 1'b1;
         end
         commit: begin
            if (can_commit) begin
               for (int k = 0; k < NUM_OPS; k++) begin
                  if (wr_ptr_q == PW'(k)) begin
                     ops_d[k*OP_W +: OP_W] = {sign, entry};
                     vld_d[k]              = 1'b1;
                  end
               end
               wr_ptr_d = wr_ptr_q + 1'b1;
               sr_clr   = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
         backspace: begin
            sr_bksp = 1'b1;
         end
         toggle_sign: begin
            sr_tog  = 1'b1;
            state_d = ENTRY;
         end
         store_digit: begin
            sr_shift = 1'b1;
            state_d  = ENTRY;
            if (state_q == ENTRY && full) ovf_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ENTRY;
         wr_ptr_q <= '0;
         ops_q    <= '0;
         vld_q    <= '0;
         res_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         ops_q    <= ops_d;
         vld_q    <= vld_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ops            = ops_q;
   assign ops_valid      = vld_q;
   assign all_ready      = &vld_q;
   assign overflow       = ovf_q;
   assign showing_result = (state_q == SHOW_RESULT);
   assign ssdec          = showing_result ? res_q[W-1:0] : entry;
   assign disp_sign      = showing_result ? res_q[OP_W-1] : sign;

endmodule

// File: tb/tb_operand_entry_buffer.sv
// Scoreboard bench for operand_entry_buffer (2x2 checked each cycle,
// 4x3 instance checked at reset and around asynchronous reset).
module tb_operand_entry_buffer;

   logic        clk;
   logic        nrst;
   logic [3:0]  digit;
   logic        sd, bk, tg, cm, clr, rr;
   logic [8:0]  result;
   logic [16:0] result_b;

   logic [17:0] a_ops;
   logic [1:0]  a_vld;
   logic        a_ar, a_ds, a_ov, a_sr;
   logic [7:0]  a_ss;

   logic [50:0] b_ops;
   logic [2:0]  b_vld;
   logic        b_ar, b_ds, b_ov, b_sr;
   logic [15:0] b_ss;

   int checks = 0;
   int errors = 0;

   operand_entry_buffer #(.DIGITS(2), .NUM_OPS(2)) dut_a (
      .clk(clk), .nrst(nrst), .digit(digit), .store_digit(sd),
      .backspace(bk), .toggle_sign(tg), .commit(cm), .clear(clr),
      .result(result), .result_ready(rr), .ops(a_ops),
      .ops_valid(a_vld), .all_ready(a_ar), .ssdec(a_ss),
      .disp_sign(a_ds), .overflow(a_ov), .showing_result(a_sr)
   );

   operand_entry_buffer #(.DIGITS(4), .NUM_OPS(3)) dut_b (
      .clk(clk), .nrst(nrst), .digit(digit), .store_digit(sd),
      .backspace(bk), .toggle_sign(tg), .commit(cm), .clear(clr),
      .result(result_b), .result_ready(rr), .ops(b_ops),
      .ops_valid(b_vld), .all_ready(b_ar), .ssdec(b_ss),
      .disp_sign(b_ds), .overflow(b_ov), .showing_result(b_sr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(string n, logic [63:0] act,
                               logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", n, act, exp);
      end
   endfunction

   // Reference model for the 2-digit, 2-slot instance.
   int       dq[$];
   bit       msgn, mshow;
   bit [8:0] mres;
   bit [8:0] mslot[2];
   bit       mval[2];
   int       mptr;

   typedef struct packed {
      logic [17:0] ops;
      logic [1:0]  v;
      logic        ar;
      logic [7:0]  ss;
      logic        ds;
      logic        ov;
      logic        sr;
   } exp_t;

   exp_t sbq[$];
   exp_t me;

   function automatic int value();
      int v = 0;
      foreach (dq[i]) v = v * 16 + dq[i];
      return v;
   endfunction

   function automatic void model_reset();
      dq.delete();
      msgn  = 0;
      mshow = 0;
      mres  = '0;
      mptr  = 0;
      for (int i = 0; i < 2; i++) begin
         mslot[i] = '0;
         mval[i]  = 0;
      end
   endfunction

   function automatic void model_step();
      exp_t e;
      bit   ov = 0;
      int   v;
      if (clr) begin
         dq.delete(); msgn = 0; mshow = 0; mptr = 0;
         mval[0] = 0; mval[1] = 0;
      end else if (rr) begin
         mres = result; mshow = 1; mptr = 0;
         mval[0] = 0; mval[1] = 0;
         dq.delete(); msgn = 0;
      end else if (cm) begin
         if (mptr < 2) begin
            v = value();
            mslot[mptr] = {msgn, 8'(v)};
            mval[mptr] = 1;
            mptr++;
            dq.delete(); msgn = 0;
         end else ov = 1;
      end else if (bk) begin
         if (dq.size() > 0) void'(dq.pop_back());
      end else if (tg) begin
         if (mshow) begin
            mshow = 0; dq.delete(); msgn = 0;
         end
         msgn = ~msgn;
      end else if (sd) begin
         if (mshow) begin
            mshow = 0; dq.delete(); dq.push_back(int'(digit)); msgn = 0;
         end else if (dq.size() < 2) dq.push_back(int'(digit));
         else ov = 1;
      end
      v    = value();
      e.ops = {mslot[1], mslot[0]};
      e.v   = {mval[1], mval[0]};
      e.ar  = mval[0] & mval[1];
      e.ss  = mshow ? mres[7:0] : 8'(v);
      e.ds  = mshow ? mres[8] : msgn;
      e.ov  = ov;
      e.sr  = mshow;
      sbq.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (nrst && sbq.size() > 0) begin
         me = sbq.pop_front();
         chk("ops",            64'(a_ops), 64'(me.ops));
         chk("ops_valid",      64'(a_vld), 64'(me.v));
         chk("all_ready",      64'(a_ar),  64'(me.ar));
         chk("ssdec",          64'(a_ss),  64'(me.ss));
         chk("disp_sign",      64'(a_ds),  64'(me.ds));
         chk("overflow",       64'(a_ov),  64'(me.ov));
         chk("showing_result", 64'(a_sr),  64'(me.sr));
      end
   end

   task automatic cyc(input bit c, input bit r, input bit m,
                      input bit b, input bit t, input bit s,
                      input logic [3:0] d, input logic [8:0] rs);
      @(negedge clk);
      clr = c; rr = r; cm = m; bk = b; tg = t; sd = s;
      digit = d; result = rs;
      @(posedge clk);
      model_step();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 4'h0, 9'h0);
   endtask

   task automatic put(input logic [3:0] d);
      cyc(0, 0, 0, 0, 0, 1, d, 9'h0);
   endtask

   task automatic zero_chk(string tag);
      chk({tag, "_a_ops"}, 64'(a_ops), 64'h0);
      chk({tag, "_a_vld"}, 64'(a_vld), 64'h0);
      chk({tag, "_a_ar"},  64'(a_ar),  64'h0);
      chk({tag, "_a_ss"},  64'(a_ss),  64'h0);
      chk({tag, "_a_ds"},  64'(a_ds),  64'h0);
      chk({tag, "_a_ov"},  64'(a_ov),  64'h0);
      chk({tag, "_a_sr"},  64'(a_sr),  64'h0);
      chk({tag, "_b_ops"}, 64'(b_ops), 64'h0);
      chk({tag, "_b_vld"}, 64'(b_vld), 64'h0);
      chk({tag, "_b_ss"},  64'(b_ss),  64'h0);
      chk({tag, "_b_sr"},  64'(b_sr),  64'h0);
   endtask

   initial begin
      nrst = 1'b0;
      {clr, rr, cm, bk, tg, sd} = '0;
      digit    = '0;
      result   = '0;
      result_b = '0;
      model_reset();
      #3;
      zero_chk("reset");
      @(negedge clk);
      nrst = 1'b1;

      // 3, 7, commit
      put(4'h3); put(4'h7);
      cyc(0, 0, 1, 0, 0, 0, 4'h0, 9'h0);
      #1;
      chk("t1_slot0", 64'(a_ops[8:0]), 64'h037);
      chk("t1_ssdec", 64'(a_ss), 64'h00);
      chk("t1_valid", 64'(a_vld), 64'h1);
      chk("t1_ready", 64'(a_ar), 64'h0);
      cyc(1, 0, 0, 0, 0, 0, 4'h0, 9'h0);

      // -5 and 9, then a rejected third commit
      put(4'h5);
      cyc(0, 0, 0, 0, 1, 0, 4'h0, 9'h0);
      cyc(0, 0, 1, 0, 0, 0, 4'h0, 9'h0);
      put(4'h9);
      cyc(0, 0, 1, 0, 0, 0, 4'h0, 9'h0);
      #1;
      chk("t2_ops", 64'(a_ops), 64'({9'h009, 9'h105}));
      chk("t2_ready", 64'(a_ar), 64'h1);
      cyc(0, 0, 1, 0, 0, 0, 4'h0, 9'h0);
      #1;
      chk("t2_ovf", 64'(a_ov), 64'h1);
      idle();
      #1;
      chk("t2_ovf_drop", 64'(a_ov), 64'h0);
      chk("t2_ops_kept", 64'(a_ops), 64'({9'h009, 9'h105}));

      // Third digit dropped, then backspace past empty
      cyc(1, 0, 0, 0, 0, 0, 4'h0, 9'h0);
      put(4'h1); put(4'h2); put(4'h3);
      #1;
      chk("t3_ovf", 64'(a_ov), 64'h1);
      chk("t3_ssdec", 64'(a_ss), 64'h12);
      chk("t3_b_ssdec", 64'(b_ss), 64'h0123);
      cyc(0, 0, 0, 1, 0, 0, 4'h0, 9'h0);
      #1;
      chk("t3_bs1", 64'(a_ss), 64'h01);
      cyc(0, 0, 0, 1, 0, 0, 4'h0, 9'h0);
      cyc(0, 0, 0, 1, 0, 0, 4'h0, 9'h0);
      #1;
      chk("t3_bs3", 64'(a_ss), 64'h00);
      chk("t3_bs3_ovf", 64'(a_ov), 64'h0);

      // Result display, then fresh digit
      cyc(0, 1, 0, 0, 0, 0, 4'h0, 9'h1A4);
      #1;
      chk("t4_show", 64'(a_sr), 64'h1);
      chk("t4_ssdec", 64'(a_ss), 64'hA4);
      chk("t4_sign", 64'(a_ds), 64'h1);
      chk("t4_valid", 64'(a_vld), 64'h0);
      put(4'h6);
      #1;
      chk("t4_entry", 64'(a_sr), 64'h0);
      chk("t4_ss6", 64'(a_ss), 64'h06);
      chk("t4_sign6", 64'(a_ds), 64'h0);

      // Priority collisions
      cyc(1, 0, 0, 0, 0, 1, 4'h8, 9'h0);
      #1;
      chk("t5_clr_sd", 64'(a_ss), 64'h00);
      put(4'h3);
      cyc(0, 1, 1, 0, 0, 0, 4'h0, 9'h055);
      #1;
      chk("t5_rr_cm_show", 64'(a_sr), 64'h1);
      chk("t5_rr_cm_valid", 64'(a_vld), 64'h0);
      cyc(0, 0, 0, 0, 1, 0, 4'h0, 9'h0);
      #1;
      chk("t5_tog_sign", 64'(a_ds), 64'h1);
      chk("t5_tog_show", 64'(a_sr), 64'h0);

      // Asynchronous reset mid-entry
      cyc(1, 0, 0, 0, 0, 0, 4'h0, 9'h0);
      put(4'h4); put(4'h2);
      cyc(0, 0, 0, 0, 1, 0, 4'h0, 9'h0);
      cyc(0, 0, 1, 0, 0, 0, 4'h0, 9'h0);
      put(4'h4); put(4'h2);
      #1;
      chk("t6_a_pre", 64'(a_ss), 64'h42);
      chk("t6_b_pre", 64'(b_ss), 64'h0042);
      @(negedge clk);
      {clr, rr, cm, bk, tg, sd} = '0;
      #2;
      nrst = 1'b0;
      #1;
      zero_chk("arst");
      sbq.delete();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      put(4'h5);
      #1;
      chk("t6_a_post", 64'(a_ss), 64'h05);
      chk("t6_b_post", 64'(b_ss), 64'h0005);

      // Random multi-strobe traffic
      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(19) == 0, $urandom_range(14) == 0,
             $urandom_range(4) == 0, $urandom_range(5) == 0,
             $urandom_range(7) == 0, $urandom_range(1) == 0,
             4'($urandom), 9'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", 64'(sbq.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
